// File: rtl/fifo_pkg.sv
// Shared definitions for the sample-RAM FIFO: readout FSM states and the
// default data/address widths used by the RAM, the write side and the reader.
package fifo_pkg;

  localparam int DEFAULT_DATA_SIZE = 12;
  localparam int DEFAULT_ADDR_SIZE = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_out_stage.sv
// Valid/ready output register for the FIFO reader. Loads a sample when the
// controller asks, holds it stable while the consumer stalls, and drops valid
// after an accept that is not immediately followed by a new load.
module fifo_out_stage import fifo_pkg::*; #(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last
);

  // Output register: clear beats load, load beats the plain accept-drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (clear) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load_en) begin
      m_data  <= ld_data;
      m_valid <= 1'b1;
      m_last  <= ld_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      m_valid <= m_valid;
      m_last  <= m_last;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the oscilloscope sample RAM. Walks the RAM's
// asynchronous read port from a start address for a given sample count and
// streams the samples through a registered valid/ready port with a last flag.
// Optional feature macro: FIFO_READER_DECIM_EN adds decim_i (address stride
// minus one, sampled with start_i).
module fifo_reader import fifo_pkg::*; #(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_SIZE-1:0] start_addr_i,
  input  logic [ADDR_SIZE:0]   length_i,
  input  logic                 abort_i,
  output logic [ADDR_SIZE-1:0] r_addr_o,
  input  logic [DATA_SIZE-1:0] r_data_i,
  output logic [DATA_SIZE-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef FIFO_READER_DECIM_EN
  ,
  input  logic [3:0]           decim_i
`endif
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   LEN_ZERO = {(ADDR_SIZE+1){1'b0}};
  localparam logic [ADDR_SIZE:0]   LEN_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};

  state_e               state_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [ADDR_SIZE:0]   remaining_r;
  logic                 busy_r;
  logic                 done_r;
  logic [ADDR_SIZE-1:0] stride_s;
  logic                 load_s;
  logic                 clear_s;
  logic                 last_s;
  logic                 accept_last_s;

`ifdef FIFO_READER_DECIM_EN
  logic [3:0]           decim_r;
  assign stride_s = ADDR_SIZE'(decim_r) + ADDR_ONE;
`else
  assign stride_s = ADDR_ONE;
`endif

  // Abort drops the output register at once; a load never coincides with it.
  assign clear_s       = (state_r == STREAM) && abort_i;
  assign load_s        = (state_r == STREAM) && !abort_i &&
                         (remaining_r != LEN_ZERO) && (!m_valid_o || m_ready_i);
  assign last_s        = (remaining_r == LEN_ONE);
  assign accept_last_s = m_valid_o && m_ready_i && m_last_o;

  assign r_addr_o = addr_r;
  assign busy_o   = busy_r;
  assign done_o   = done_r;

  // Readout FSM with address/count registers and registered busy/done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      remaining_r <= LEN_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef FIFO_READER_DECIM_EN
      decim_r     <= 4'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_i && (length_i != LEN_ZERO) && !abort_i) begin
            state_r     <= STREAM;
            addr_r      <= start_addr_i;
            remaining_r <= length_i;
            busy_r      <= 1'b1;
`ifdef FIFO_READER_DECIM_EN
            decim_r     <= decim_i;
`endif
          end
        end
        STREAM: begin
          done_r <= 1'b0;
          if (abort_i) begin
            state_r     <= IDLE;
            remaining_r <= LEN_ZERO;
            busy_r      <= 1'b0;
          end else if (accept_last_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (load_s) begin
            addr_r      <= addr_r + stride_s;
            remaining_r <= remaining_r - LEN_ONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          remaining_r <= LEN_ZERO;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  fifo_out_stage #(
    .DATA_SIZE (DATA_SIZE)
  ) u_out_stage (
    .clk     (clk_i),
    .rst     (rst_i),
    .load_en (load_s),
    .clear   (clear_s),
    .ld_data (r_data_i),
    .ld_last (last_s),
    .m_ready (m_ready_i),
    .m_data  (m_data_o),
    .m_valid (m_valid_o),
    .m_last  (m_last_o)
  );

endmodule
